fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences a single-port-write/single-port-read RAM of depth 2^SIZE. It owns the write and read pointers, qualifies write and read requests against the full/empty state, and drives RAM address and enable lines. It produces full, empty, almost and occupancy status, plus a registered read-valid strobe. It sits between the FIFO's producer/consumer interfaces and the storage array, and is the sole owner of pointer state.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_ptr.sv | 16 +
 rtl/fifo_ctrl.sv | 81 ++++++++
 tb/tb_fifo_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO controller types, default geometry and pointer arithmetic
package fifo_pkg;
  localparam int DEF_SIZE = 4;
  localparam int DEF_AF_LEVEL = (1 << DEF_SIZE) - 2;
  localparam int DEF_AE_LEVEL = 2;
  typedef logic [DEF_SIZE:0] ptr_t;
  function automatic logic [31:0] ptr_inc(input logic [31:0] p);
    return p + 32'd1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: SIZE+1-bit wrapping pointer register with increment enable
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [SIZE:0] ptr
);
  logic [SIZE:0] ptr_q, ptr_d;
  always_comb ptr_d = en ? (SIZE+1)'(ptr_inc(32'(ptr_q))) : ptr_q;
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status controller for a 2^SIZE-deep FIFO RAM.
// Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow registers.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int AF_LEVEL = (1 << SIZE) - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_req,
  input  logic            rd_req,
  output logic            mem_we,
  output logic            mem_re,
  output logic [SIZE-1:0] w_addr,
  output logic [SIZE-1:0] r_addr,
  output logic            rd_valid,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [SIZE:0]   count,
  output logic            overflow,
  output logic            underflow
);
  localparam logic [SIZE:0] AF = (SIZE+1)'(AF_LEVEL);
  localparam logic [SIZE:0] AE = (SIZE+1)'(AE_LEVEL);
  logic [SIZE:0] wp, rp, count_q, count_d;
  logic          wr_acc, rd_acc, rd_valid_q, rd_valid_d;
  fifo_ptr #(.SIZE(SIZE)) u_wp (.clk(clk), .rst(rst), .en(wr_acc), .ptr(wp));
  fifo_ptr #(.SIZE(SIZE)) u_rp (.clk(clk), .rst(rst), .en(rd_acc), .ptr(rp));
  // Accepts are masked during reset so the RAM sees no write in that cycle
  always_comb begin
    empty = wp == rp;
    full = (wp[SIZE] != rp[SIZE]) && (wp[SIZE-1:0] == rp[SIZE-1:0]);
    wr_acc = wr_req & ~full & ~rst;
    rd_acc = rd_req & ~empty & ~rst;
    count_d = (wr_acc && !rd_acc) ? count_q + 1'b1 :
              (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
    rd_valid_d = rd_acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign mem_we = wr_acc;
  assign mem_re = rd_acc;
  assign w_addr = wp[SIZE-1:0];
  assign r_addr = rp[SIZE-1:0];
  assign rd_valid = rd_valid_q;
  assign count = count_q;
  assign almost_full = count_q >= AF;
  assign almost_empty = count_q <= AE;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  always_comb begin
    overflow_d = overflow_q | (wr_req & full);
    underflow_d = underflow_q | (rd_req & empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign overflow = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl at SIZE=4
module tb_fifo_ctrl;
  import fifo_pkg::*;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, wr_req = 1'b0, rd_req = 1'b0;
  logic mem_we, mem_re, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] w_addr, r_addr;
  logic [4:0] count;
  int checks = 0, errors = 0;
  int m = 0;
  ptr_t wp_m = '0, rp_m = '0;
  bit rv_m = 0, ovf_m = 0, udf_m = 0;
  fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
    .mem_we(mem_we), .mem_re(mem_re), .w_addr(w_addr), .r_addr(r_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic status(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m));
    chk({tag, ".full"}, 32'(full), 32'(m == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(m == 0));
    chk({tag, ".af"}, 32'(almost_full), 32'(m >= 14));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(m <= 2));
    chk({tag, ".w_addr"}, 32'(w_addr), 32'(wp_m[3:0]));
    chk({tag, ".r_addr"}, 32'(r_addr), 32'(rp_m[3:0]));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(rv_m));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ERR_EN & ovf_m));
    chk({tag, ".udf"}, 32'(underflow), 32'(ERR_EN & udf_m));
  endtask
  task automatic step(input string tag, input bit w, input bit r);
    bit wa, ra;
    wr_req = w;
    rd_req = r;
    #1;
    wa = w && m != 16;
    ra = r && m != 0;
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(wa));
    chk({tag, ".mem_re"}, 32'(mem_re), 32'(ra));
    ovf_m |= w && m == 16;
    udf_m |= r && m == 0;
    tick();
    wr_req = 0;
    rd_req = 0;
    m = m + int'(wa) - int'(ra);
    wp_m = wp_m + ptr_t'(wa);
    rp_m = rp_m + ptr_t'(ra);
    rv_m = ra;
    status(tag);
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    tick();
    chk("rst.empty", 32'(empty), 1);
    chk("rst.ae", 32'(almost_empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.af", 32'(almost_full), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.w_addr", 32'(w_addr), 0);
    chk("rst.r_addr", 32'(r_addr), 0);
    chk("rst.rd_valid", 32'(rd_valid), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.udf", 32'(underflow), 0);
    for (int i = 1; i <= 16; i++) begin
      step("fill", 1, 0);
      if (i == 13) chk("fill13.af", 32'(almost_full), 0);
      if (i == 14) chk("fill14.af", 32'(almost_full), 1);
    end
    chk("fill16.full", 32'(full), 1);
    chk("fill16.count", 32'(count), 16);
    step("wr_full", 1, 0);
    chk("wr_full.count", 32'(count), 16);
    chk("wr_full.w_addr", 32'(w_addr), 0);
    chk("wr_full.ovf", 32'(overflow), 32'(ERR_EN));
    step("idle_full", 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'(ERR_EN));
    step("both_full", 1, 1);
    chk("both_full.count", 32'(count), 15);
    chk("both_full.full", 32'(full), 0);
    chk("both_full.rd_valid", 32'(rd_valid), 1);
    for (int i = 0; i < 15; i++) step("drain", 0, 1);
    chk("drain.empty", 32'(empty), 1);
    step("both_empty", 1, 1);
    chk("both_empty.count", 32'(count), 1);
    chk("both_empty.rd_valid", 32'(rd_valid), 0);
    chk("both_empty.udf", 32'(underflow), 32'(ERR_EN));
    step("pre_wrap", 1, 0);
    step("pre_wrap", 1, 0);
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) begin
        step("wrap_w", 1, 0);
        step("wrap_r", 0, 1);
      end else begin
        step("wrap_b", 1, 1);
      end
    end
    chk("wrap.count", 32'(count), 3);
    for (int i = 0; i < 6; i++) step("to9", 1, 0);
    chk("to9.count", 32'(count), 9);
    rst = 1;
    wr_req = 1;
    tick();
    rst = 0;
    wr_req = 0;
    m = 0;
    wp_m = '0;
    rp_m = '0;
    rv_m = 0;
    ovf_m = 0;
    udf_m = 0;
    chk("midrst.count", 32'(count), 0);
    chk("midrst.empty", 32'(empty), 1);
    status("midrst");
    step("post_rst", 1, 0);
    chk("post_rst.w_addr", 32'(w_addr), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
